// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial adder.
// Holds the FSM state encoding and the signed-overflow rule.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } add_state_t;

  function automatic logic ovf_flag(
    input logic am,
    input logic bm,
    input logic sm
  );
    return (am == bm) && (sm != am);
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational ripple adder for one slice of the serial adder.
// Each full adder is two half adders plus an OR on the carries.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module slice_adder #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
      .a(a[i]),
      .b(b[i]),
      .s(s1),
      .c(c1)
    );

    half_adder u_ha1 (
      .a(s1),
      .b(c[i]),
      .s(sum[i]),
      .c(c2)
    );

    assign c[i+1] = c1 | c2;
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: SLICE bits per clock with a registered carry,
// valid/ready handshakes on both sides, carry-out and overflow flags.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SDIV = (SLICE < 1) ? 1 : SLICE;
  localparam int N    = WIDTH / SDIV;
  localparam int CW   = $clog2(N + 1);

  if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH ||
      (WIDTH % SDIV) != 0) begin : g_bad_param
    $error("serial_adder: bad WIDTH/SLICE combination");
  end

  add_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             last;

  slice_adder #(
    .SLICE(SLICE)
  ) u_slice (
    .a   (a_sr[SLICE-1:0]),
    .b   (b_sr[SLICE-1:0]),
    .cin (carry),
    .sum (s_sum),
    .cout(s_cout)
  );

  // Results enter at the MSB end so the first slice ends at bit 0.
  if (SLICE == WIDTH) begin : g_full
    assign sum_nxt = s_sum;
  end else begin : g_part
    assign sum_nxt = {s_sum, sum_r[WIDTH-1:SLICE]};
  end

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum_r <= sum_nxt;
          a_sr  <= a_sr >> SLICE;
          b_sr  <= b_sr >> SLICE;
          carry <= s_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout_r <= s_cout;
            ovf_r  <= ovf_flag(a_msb, b_msb,
                               s_sum[SLICE-1]);
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four configurations checked against
// an arithmetic reference model, plus handshake and reset cases.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       in_valid  [4];
  logic       out_ready [4];
  logic       cin_i     [4];
  logic [7:0] a_i       [4];
  logic [7:0] b_i       [4];
  logic       in_ready_o  [4];
  logic       out_valid_o [4];
  logic       cout_o      [4];
  logic       ovf_o       [4];
  logic [7:0] sum_o       [4];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 3) ? 1 : 8;
    localparam int S = (g == 0) ? 1 :
                       (g == 1) ? 2 :
                       (g == 2) ? 8 : 1;
    logic [W-1:0] s;

    serial_adder #(
      .WIDTH(W),
      .SLICE(S)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready_o[g]),
      .a        (a_i[g][W-1:0]),
      .b        (b_i[g][W-1:0]),
      .cin      (cin_i[g]),
      .out_valid(out_valid_o[g]),
      .out_ready(out_ready[g]),
      .sum      (s),
      .cout     (cout_o[g]),
      .ovf      (ovf_o[g])
    );

    assign sum_o[g] = 8'(s);
  end

  function automatic int wid(input int i);
    return (i == 3) ? 1 : 8;
  endfunction

  function automatic int ncyc(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] ref_add(
    input int       w,
    input logic [7:0] av,
    input logic [7:0] bv,
    input logic     ci
  );
    int mask, ua, ub, s, sa, sb, ss, hi, lo;
    logic ov, co;
    mask = (1 << w) - 1;
    ua = int'(av) & mask;
    ub = int'(bv) & mask;
    s  = ua + ub + int'(ci);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    ss = sa + sb + int'(ci);
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    ov = (ss > hi) || (ss < lo);
    co = ((s >> w) & 1) != 0;
    return {ov, co, 8'(s & mask)};
  endfunction

  task automatic do_op(
    input int       i,
    input logic [7:0] av,
    input logic [7:0] bv,
    input logic     ci,
    input string    tag
  );
    logic [9:0] e;
    int t, lat;
    e = ref_add(wid(i), av, bv, ci);
    @(negedge clk);
    a_i[i] = av;
    b_i[i] = bv;
    cin_i[i] = ci;
    in_valid[i] = 1'b1;
    t = 0;
    while (!in_ready_o[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_o[i]) check({tag, "_acc"}, 32'(in_ready_o[i]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    a_i[i] = 8'($urandom);
    b_i[i] = 8'($urandom);
    cin_i[i] = 1'($urandom);
    lat = 0;
    while (!out_valid_o[i] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_vld"}, 32'(out_valid_o[i]), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(ncyc(i)));
    check({tag, "_sum"}, 32'(sum_o[i]), 32'(e[7:0]));
    check({tag, "_cout"}, 32'(cout_o[i]), 32'(e[8]));
    check({tag, "_ovf"}, 32'(ovf_o[i]), 32'(e[9]));
  endtask

  initial begin
    logic [9:0] e;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      cin_i[i] = 1'b0;
      a_i[i] = 8'h00;
      b_i[i] = 8'h00;
    end
    in_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_inrdy", 32'(in_ready_o[i]), 32'd1);
      check("rst_ovld", 32'(out_valid_o[i]), 32'd0);
      check("rst_sum", 32'(sum_o[i]), 32'd0);
      check("rst_cout", 32'(cout_o[i]), 32'd0);
      check("rst_ovf", 32'(ovf_o[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid[0] = 1'b0;

    do_op(0, 8'hFF, 8'h01, 1'b0, "t1");
    check("t1_sumk", 32'(sum_o[0]), 32'h00);
    @(posedge clk);
    #1;
    check("t1_inrdy", 32'(in_ready_o[0]), 32'd1);
    check("t1_ovld", 32'(out_valid_o[0]), 32'd0);
    check("t1_hold", 32'(sum_o[0]), 32'h00);

    do_op(1, 8'h7F, 8'h01, 1'b0, "t2");
    check("t2_sumk", 32'(sum_o[1]), 32'h80);
    check("t2_ovfk", 32'(ovf_o[1]), 32'd1);
    do_op(2, 8'h3C, 8'hC3, 1'b1, "t3");
    check("t3_coutk", 32'(cout_o[2]), 32'd1);

    out_ready[0] = 1'b0;
    e = ref_add(8, 8'h96, 8'h8B, 1'b0);
    do_op(0, 8'h96, 8'h8B, 1'b0, "t4");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("t4_ovld", 32'(out_valid_o[0]), 32'd1);
      check("t4_inrdy", 32'(in_ready_o[0]), 32'd0);
      check("t4_sum", 32'(sum_o[0]), 32'(e[7:0]));
      check("t4_cout", 32'(cout_o[0]), 32'(e[8]));
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t4_rel", 32'(in_ready_o[0]), 32'd1);

    @(negedge clk);
    a_i[0] = 8'hFF;
    b_i[0] = 8'hFF;
    cin_i[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_inrdy", 32'(in_ready_o[0]), 32'd1);
    check("t5_ovld", 32'(out_valid_o[0]), 32'd0);
    check("t5_sum", 32'(sum_o[0]), 32'd0);
    check("t5_cout", 32'(cout_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_nores", 32'(out_valid_o[0]), 32'd0);
    do_op(0, 8'h05, 8'h03, 1'b0, "t5b");
    check("t5b_sumk", 32'(sum_o[0]), 32'h08);

    for (int k = 0; k < 8; k++) begin
      do_op(3, 8'(k & 1), 8'((k >> 1) & 1), 1'(k >> 2), "ha");
    end

    for (int k = 0; k < 1000; k++) begin
      do_op(k % 4, 8'($urandom), 8'($urandom),
            1'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
